// File: rtl/rr_grant_sched_pkg.sv
// rr_grant_sched_pkg: shared constants, FSM state type and the round-robin
// scan helper used by the grant scheduler.
package rr_grant_sched_pkg;

   // Number of requesters sharing the decoded resource.
   localparam int unsigned NREQ  = 4;

   // Width of the encoded owner index (log2 of NREQ).
   localparam int unsigned IDX_W = 2;

   // Scheduler states. Encoding 2'd3 is unused; the next-state logic
   // treats it as illegal and returns to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // Round-robin pick: first set request bit scanning ptr, ptr+1, ptr+2,
   // ptr+3 with mod-NREQ wrap (natural from the IDX_W-bit addition).
   // Returns ptr when no bit is set; callers only use the result when
   // at least one request is pending.
   function automatic logic [IDX_W-1:0] rr_pick(
      input logic [NREQ-1:0]  req,
      input logic [IDX_W-1:0] ptr
   );
      logic [IDX_W-1:0] cand;
      logic [IDX_W-1:0] pick;
      logic             found;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = ptr + IDX_W'(k);
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_grant_sched_grant_dec.sv
// grant_dec: 2-to-4 decoder driving the shared resource select lines.
// Output is non-zero only when the active-high enable is set and the
// active-low enable is clear.
module grant_dec
   import rr_grant_sched_pkg::*;
(
   input  logic [IDX_W-1:0] gnt_idx_i,
   input  logic             gnt_valid_i,
   input  logic             en_l_i,
   output logic [NREQ-1:0]  gnt_o
);

   // Decode the owner index into a one-hot select when both enables agree.
   always_comb begin
      gnt_o = '0;
      if (gnt_valid_i && !en_l_i) begin
         gnt_o[gnt_idx_i] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_grant_sched.sv
// rr_grant_sched: round-robin owner scheduler for one decoded resource.
// Grants one requester at a time, bounds ownership with a hold timeout and
// inserts a dead cycle (GAP) plus an arbitration cycle (IDLE) between
// owners so the select lines never overlap.
module rr_grant_sched
   import rr_grant_sched_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [NREQ-1:0]  REQ,
   input  logic             DONE,
   output logic [NREQ-1:0]  GNT,
   output logic [IDX_W-1:0] GNT_IDX,
   output logic             GNT_VALID,
   output logic             EN_L,
   output logic             TIMEOUT,
   output logic             BUSY
);

   // Counter value seen in the last permitted ownership cycle, and the
   // saturation ceiling of the hold counter.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rel_normal;
   logic             rel_forced;

   // State register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: arbitrate in IDLE, evaluate release in OWN, one dead cycle in GAP.
   always_comb begin
      rel_normal = 1'b0;
      rel_forced = 1'b0;
      state_d    = ST_IDLE;
      case (state_q)
         ST_IDLE: begin
            state_d = (|REQ) ? ST_OWN : ST_IDLE;
         end
         ST_OWN: begin
            // DONE or the owner dropping its request wins over the timeout.
            rel_normal = DONE | ~REQ[idx_q];
            rel_forced = ~rel_normal & (cnt_q == HOLD_LAST);
            state_d    = (rel_normal | rel_forced) ? ST_GAP : ST_OWN;
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output / datapath next values: grant index, valid, hold counter, pointer, timeout pulse.
   always_comb begin
      idx_d     = idx_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|REQ) begin
               idx_d   = rr_pick(REQ, ptr_q);
               valid_d = 1'b1;
               cnt_d   = '0;
            end
         end
         ST_OWN: begin
            if (cnt_q != HOLD_SAT) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (rel_normal | rel_forced) begin
               // Just-served requester becomes lowest priority next round.
               ptr_d     = idx_q + IDX_W'(1);
               valid_d   = 1'b0;
               timeout_d = rel_forced;
            end
         end
         default: begin
            valid_d = 1'b0;
         end
      endcase
      BUSY = (state_q == ST_OWN) || (state_q == ST_GAP);
   end

   // Datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         idx_q     <= '0;
         ptr_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
      end
   end

   assign GNT_IDX   = idx_q;
   assign GNT_VALID = valid_q;
   assign EN_L      = ~valid_q;
   assign TIMEOUT   = timeout_q;

   grant_dec u_grant_dec (
      .gnt_idx_i   (idx_q),
      .gnt_valid_i (valid_q),
      .en_l_i      (~valid_q),
      .gnt_o       (GNT)
   );

endmodule

// File: tb/tb_rr_grant_sched.sv
// tb_rr_grant_sched: table vectors, hand-written corner sequences and a
// randomized run checked against a cycle-level behavioural model.
module tb_rr_grant_sched;

   localparam int MH = 8;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [3:0] REQ = 4'b0000;
   logic       DONE = 1'b0;
   logic [3:0] GNT;
   logic [1:0] GNT_IDX;
   logic       GNT_VALID;
   logic       EN_L;
   logic       TIMEOUT;
   logic       BUSY;

   rr_grant_sched #(.MAX_HOLD(MH), .CNT_W(8)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .REQ       (REQ),
      .DONE      (DONE),
      .GNT       (GNT),
      .GNT_IDX   (GNT_IDX),
      .GNT_VALID (GNT_VALID),
      .EN_L      (EN_L),
      .TIMEOUT   (TIMEOUT),
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: owner (-1 = none), cycles held, dead-cycle flag,
   // next-round starting requester.
   int m_owner = -1;
   int m_last  = 0;
   int m_held  = 0;
   int m_ptr   = 0;
   bit m_gap   = 1'b0;
   bit m_to    = 1'b0;

   task automatic model_edge(input bit rst, input logic [3:0] req, input bit done);
      bit found;
      int cand;
      if (rst) begin
         m_owner = -1; m_last = 0; m_held = 0; m_ptr = 0; m_gap = 1'b0; m_to = 1'b0;
      end else begin
         m_to = 1'b0;
         if (m_owner >= 0) begin
            m_held++;
            if (done || !req[m_owner] || m_held == MH) begin
               m_to    = !(done || !req[m_owner]);
               m_ptr   = (m_owner + 1) % 4;
               m_owner = -1;
               m_gap   = 1'b1;
            end
         end else if (m_gap) begin
            m_gap = 1'b0;
         end else if (req != 4'b0000) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
               cand = (m_ptr + k) % 4;
               if (!found && req[cand]) begin
                  found   = 1'b1;
                  m_owner = cand;
                  m_last  = cand;
                  m_held  = 0;
               end
            end
         end
      end
   endtask

   task automatic model_check();
      int exp_gnt;
      exp_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
      chk("model_gnt", int'(GNT), exp_gnt);
      chk("model_valid", int'(GNT_VALID), int'(m_owner >= 0));
      chk("model_en_l", int'(EN_L), int'(m_owner < 0));
      chk("model_timeout", int'(TIMEOUT), int'(m_to));
      chk("model_busy", int'(BUSY), int'((m_owner >= 0) || m_gap));
      if (m_owner >= 0) chk("model_idx", int'(GNT_IDX), m_last);
   endtask

   // One clock: drive inputs, take the edge, sample 1 time unit later.
   task automatic step(input bit rst, input logic [3:0] req, input bit done);
      RESET = rst;
      REQ   = req;
      DONE  = done;
      @(posedge CLK);
      model_edge(rst, req, done);
      #1;
      model_check();
   endtask

   typedef struct {
      bit         rst;
      logic [3:0] req;
      bit         done;
      logic [3:0] gnt;
      int         idx;
      bit         valid;
      bit         to;
      bit         busy;
   } vec_t;

   function automatic vec_t mk(input bit rst, input logic [3:0] req, input bit done,
                               input logic [3:0] gnt, input int idx, input bit valid,
                               input bit to, input bit busy);
      vec_t v;
      v.rst = rst; v.req = req; v.done = done; v.gnt = gnt;
      v.idx = idx; v.valid = valid; v.to = to; v.busy = busy;
      return v;
   endfunction

   vec_t tbl[$];
   int   zeros;
   int   held;
   int   tocnt;
   logic [3:0] rq;
   logic [3:0] exp_g;

   initial begin
      // rst req done | gnt idx valid to busy   (outputs seen after the edge)
      tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2, 1, 0, 1));  // 1-cycle grant latency
      tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2, 1, 0, 1));
      tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2, 1, 0, 1));
      tbl.push_back(mk(0, 4'b0100, 1, 4'b0000, 0, 0, 0, 1));  // DONE -> GAP
      tbl.push_back(mk(0, 4'b0100, 0, 4'b0000, 0, 0, 0, 0));  // IDLE, ptr=3
      tbl.push_back(mk(0, 4'b1000, 0, 4'b1000, 3, 1, 0, 1));
      tbl.push_back(mk(0, 4'b0101, 0, 4'b0000, 0, 0, 0, 1));  // owner drops REQ
      tbl.push_back(mk(0, 4'b0101, 0, 4'b0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0101, 0, 4'b0001, 0, 1, 0, 1));  // wrap to index 0
      tbl.push_back(mk(0, 4'b0101, 1, 4'b0000, 0, 0, 0, 1));
      tbl.push_back(mk(0, 4'b0101, 0, 4'b0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0101, 0, 4'b0100, 2, 1, 0, 1));  // then index 2
      tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1));
      tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 1, 0, 1));
      tbl.push_back(mk(1, 4'b0010, 0, 4'b0000, 0, 0, 0, 0));  // reset mid-OWN
      tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].req, tbl[i].done);
         chk($sformatf("vec%0d_gnt", i), int'(GNT), int'(tbl[i].gnt));
         chk($sformatf("vec%0d_valid", i), int'(GNT_VALID), int'(tbl[i].valid));
         chk($sformatf("vec%0d_en_l", i), int'(EN_L), int'(!tbl[i].valid));
         chk($sformatf("vec%0d_timeout", i), int'(TIMEOUT), int'(tbl[i].to));
         chk($sformatf("vec%0d_busy", i), int'(BUSY), int'(tbl[i].busy));
         if (tbl[i].valid || tbl[i].rst)
            chk($sformatf("vec%0d_idx", i), int'(GNT_IDX), tbl[i].idx);
      end

      // Round-robin with all four requesting, DONE one cycle after each grant.
      step(1, 4'b0000, 0);
      for (int n = 0; n < 5; n++) begin
         zeros = 0;
         for (int w = 0; w < 8 && GNT == 4'b0000; w++) begin
            zeros++;
            step(0, 4'b1111, 0);
         end
         exp_g = 4'b0001 << (n % 4);
         chk($sformatf("rr%0d_gnt", n), int'(GNT), int'(exp_g));
         if (n > 0) chk($sformatf("rr%0d_gap_cycles", n), zeros, 2);
         step(0, 4'b1111, 0);
         chk($sformatf("rr%0d_hold", n), int'(GNT), int'(exp_g));
         step(0, 4'b1111, 1);
         chk($sformatf("rr%0d_release", n), int'(GNT), 0);
      end

      // Timeout: single requester holds without DONE.
      step(1, 4'b0000, 0);
      step(0, 4'b0010, 0);
      held = 0;
      tocnt = 0;
      for (int w = 0; w < 20 && GNT == 4'b0010; w++) begin
         held++;
         if (TIMEOUT) tocnt++;
         step(0, 4'b0010, 0);
      end
      chk("to_hold_cycles", held, MH);
      chk("to_early_pulse", tocnt, 0);
      chk("to_pulse", int'(TIMEOUT), 1);
      chk("to_gap_gnt", int'(GNT), 0);
      step(0, 4'b0010, 0);
      chk("to_pulse_len", int'(TIMEOUT), 0);
      chk("to_idle_gnt", int'(GNT), 0);
      step(0, 4'b0010, 0);
      chk("to_regrant", int'(GNT), 4'b0010);

      // DONE in the same cycle as the hold limit: normal release, no TIMEOUT.
      step(1, 4'b0000, 0);
      step(0, 4'b0010, 0);
      for (int w = 0; w < MH - 1; w++) step(0, 4'b0010, 0);
      chk("sim_still_owned", int'(GNT), 4'b0010);
      step(0, 4'b0010, 1);
      chk("sim_release_gnt", int'(GNT), 0);
      chk("sim_no_timeout", int'(TIMEOUT), 0);

      // Randomized traffic against the model.
      step(1, 4'b0000, 0);
      rq = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
         step($urandom_range(0, 199) == 0, rq, $urandom_range(0, 11) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
